// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with row synchronizer and press/release debounce.
// Emits one key_strobe per accepted press, with key_pos = {col_idx, row_idx}.
module keypad_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_pos,
  output logic       key_strobe,
  output logic       key_held
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CNT);

  typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_PRESSED} state_e;

  state_e           state_q, state_d;
  logic [3:0]       rows_meta_q, rows_meta_d;
  logic [3:0]       rows_s_q, rows_s_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [3:0]       cand_pos_q, cand_pos_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       key_pos_q, key_pos_d;
  logic             key_strobe_q, key_strobe_d;
  logic             key_held_q, key_held_d;
  logic [3:0]       cols_q, cols_d;

  logic             tick;
  logic             cand_row_low;
  logic [CNT_W-1:0] cnt_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1'b1;
  endfunction

  // Lowest-index active-low row wins when several rows are pulled down.
  function automatic logic [1:0] lowest_low_row(input logic [3:0] r);
    if (!r[0])      return 2'd0;
    else if (!r[1]) return 2'd1;
    else if (!r[2]) return 2'd2;
    else            return 2'd3;
  endfunction

  assign tick         = (div_q == DIV_LAST);
  assign cand_row_low = ~rows_s_q[cand_pos_q[1:0]];
  assign cnt_inc      = sat_inc(cnt_q);

  always_comb begin
    state_d      = state_q;
    rows_meta_d  = rows;
    rows_s_d     = rows_meta_q;
    div_d        = div_q;
    col_idx_d    = col_idx_q;
    cand_pos_d   = cand_pos_q;
    cnt_d        = cnt_q;
    key_pos_d    = key_pos_q;
    key_strobe_d = 1'b0;
    key_held_d   = key_held_q;

    if (!enable) begin
      state_d    = ST_SCAN;
      div_d      = '0;
      cnt_d      = '0;
      col_idx_d  = 2'd0;
      key_held_d = 1'b0;
    end else begin
      div_d = tick ? '0 : div_q + 1'b1;
      if (tick) begin
        case (state_q)
          ST_SCAN: begin
            if (rows_s_q == 4'b1111) begin
              col_idx_d = col_idx_q + 2'd1;
            end else begin
              cand_pos_d = {col_idx_q, lowest_low_row(rows_s_q)};
              if (DEBOUNCE_CNT <= 1) begin
                state_d      = ST_PRESSED;
                key_pos_d    = {col_idx_q, lowest_low_row(rows_s_q)};
                key_strobe_d = 1'b1;
                key_held_d   = 1'b1;
                cnt_d        = '0;
              end else begin
                state_d = ST_DEBOUNCE;
                cnt_d   = CNT_W'(1);
              end
            end
          end
          ST_DEBOUNCE: begin
            if (!cand_row_low) begin
              state_d   = ST_SCAN;
              cnt_d     = '0;
              col_idx_d = col_idx_q + 2'd1;
            end else if (cnt_inc >= CNT_MAX) begin
              state_d      = ST_PRESSED;
              key_pos_d    = cand_pos_q;
              key_strobe_d = 1'b1;
              key_held_d   = 1'b1;
              cnt_d        = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
          ST_PRESSED: begin
            // cnt_q now counts consecutive high ticks of the held row.
            if (cand_row_low) begin
              cnt_d = '0;
            end else if (cnt_inc >= CNT_MAX) begin
              state_d    = ST_SCAN;
              key_held_d = 1'b0;
              cnt_d      = '0;
              col_idx_d  = col_idx_q + 2'd1;
            end else begin
              cnt_d = cnt_inc;
            end
          end
          default: state_d = ST_SCAN;
        endcase
      end
    end

    cols_d = enable ? ~(4'b0001 << col_idx_d) : 4'b1111;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_SCAN;
      rows_meta_q  <= 4'b1111;
      rows_s_q     <= 4'b1111;
      div_q        <= '0;
      col_idx_q    <= 2'd0;
      cand_pos_q   <= 4'd0;
      cnt_q        <= '0;
      key_pos_q    <= 4'd0;
      key_strobe_q <= 1'b0;
      key_held_q   <= 1'b0;
      cols_q       <= enable ? 4'b1110 : 4'b1111;
    end else begin
      state_q      <= state_d;
      rows_meta_q  <= rows_meta_d;
      rows_s_q     <= rows_s_d;
      div_q        <= div_d;
      col_idx_q    <= col_idx_d;
      cand_pos_q   <= cand_pos_d;
      cnt_q        <= cnt_d;
      key_pos_q    <= key_pos_d;
      key_strobe_q <= key_strobe_d;
      key_held_q   <= key_held_d;
      cols_q       <= cols_d;
    end
  end

  assign cols       = cols_q;
  assign key_pos    = key_pos_q;
  assign key_strobe = key_strobe_q;
  assign key_held   = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=3 and a
// behavioural 4x4 key matrix driving the rows from the column outputs.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [3:0]  key_pos;
  logic        key_strobe;
  logic        key_held;
  logic [15:0] pressed;

  int n_tests = 0;
  int n_fail  = 0;
  int k_now   = 0;
  int strobe_cnt = 0;
  int s0;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .enable    (enable),
    .rows      (rows),
    .cols      (cols),
    .key_pos   (key_pos),
    .key_strobe(key_strobe),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // Key at (c, r) is bit c*4+r; it pulls row r low while column c is driven low.
  always_comb begin
    rows = 4'b1111;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (pressed[c*4+r] && !cols[c]) rows[r] = 1'b0;
  end

  always @(negedge clk) if (key_strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, k_now);
    end
  endtask

  // k_now = number of clock edges since the last reset edge; sample 1 time unit after.
  task automatic tick_to(input int k);
    while (k_now < k) begin
      @(posedge clk);
      #1;
      k_now++;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    k_now  = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn  = 1'b0;
    enable  = 1'b1;
    pressed = 16'h0000;

    // 1: reset values, then free-running scan with no key
    do_reset();
    check_eq("rst_cols",   {28'd0, cols}, 32'hE);
    check_eq("rst_keypos", {28'd0, key_pos}, 32'h0);
    check_eq("rst_strobe", {31'd0, key_strobe}, 32'h0);
    check_eq("rst_held",   {31'd0, key_held}, 32'h0);
    s0 = strobe_cnt;
    for (int k = 0; k < 20; k++) begin
      logic [3:0] exp_cols;
      tick_to(k);
      exp_cols = ~(4'b0001 << ((k / 4) % 4));
      check_eq("scan_cols", {28'd0, cols}, {28'd0, exp_cols});
    end
    tick_to(24);
    check_eq("scan_no_strobe", strobe_cnt - s0, 0);

    // 2: key at col 1 row 2, first tick seeing it decides at edge 8
    do_reset();
    s0 = strobe_cnt;
    pressed = 16'h0040;
    tick_to(15);
    check_eq("press_pre_strobe", {31'd0, key_strobe}, 32'h0);
    check_eq("press_frozen_cols", {28'd0, cols}, 32'hD);
    tick_to(16);
    check_eq("press_strobe", {31'd0, key_strobe}, 32'h1);
    check_eq("press_keypos", {28'd0, key_pos}, 32'h6);
    check_eq("press_held_rise", {31'd0, key_held}, 32'h1);
    tick_to(17);
    check_eq("press_strobe_1cyc", {31'd0, key_strobe}, 32'h0);
    tick_to(40);
    check_eq("press_hold_cols", {28'd0, cols}, 32'hD);
    check_eq("press_hold_held", {31'd0, key_held}, 32'h1);
    check_eq("press_one_strobe", strobe_cnt - s0, 1);

    // 3: release; third high tick decides at edge 52
    pressed = 16'h0000;
    tick_to(51);
    check_eq("rel_still_held", {31'd0, key_held}, 32'h1);
    check_eq("rel_still_cols", {28'd0, cols}, 32'hD);
    tick_to(52);
    check_eq("rel_held_fall", {31'd0, key_held}, 32'h0);
    check_eq("rel_resume_cols", {28'd0, cols}, 32'hB);
    tick_to(60);
    check_eq("rel_no_extra", strobe_cnt - s0, 1);
    check_eq("rel_keypos_kept", {28'd0, key_pos}, 32'h6);

    // 4: bounce on col 0 row 0: low one tick, high the next, five times
    do_reset();
    s0 = strobe_cnt;
    for (int i = 0; i < 5; i++) begin
      tick_to(20 * i);
      pressed = 16'h0001;
      tick_to(20 * i + 4);
      pressed = 16'h0000;
      tick_to(20 * i + 7);
      check_eq("bounce_frozen", {28'd0, cols}, 32'hE);
      tick_to(20 * i + 8);
      check_eq("bounce_advance", {28'd0, cols}, 32'hD);
    end
    tick_to(104);
    check_eq("bounce_no_strobe", strobe_cnt - s0, 0);
    check_eq("bounce_no_held", {31'd0, key_held}, 32'h0);

    // 5: rows 1 and 3 in column 2, then an extra key in column 0 while held
    do_reset();
    s0 = strobe_cnt;
    pressed = 16'h0A00;
    tick_to(20);
    check_eq("multi_strobe", {31'd0, key_strobe}, 32'h1);
    check_eq("multi_keypos", {28'd0, key_pos}, 32'h9);
    tick_to(21);
    pressed = 16'h0A01;
    tick_to(40);
    check_eq("multi_held", {31'd0, key_held}, 32'h1);
    check_eq("multi_no_second", strobe_cnt - s0, 1);
    check_eq("multi_keypos_kept", {28'd0, key_pos}, 32'h9);

    // 6a: enable low while PRESSED
    enable = 1'b0;
    tick_to(42);
    check_eq("en_pressed_held", {31'd0, key_held}, 32'h0);
    check_eq("en_pressed_cols", {28'd0, cols}, 32'hF);
    check_eq("en_pressed_keypos", {28'd0, key_pos}, 32'h9);
    pressed = 16'h0000;
    tick_to(44);
    enable = 1'b1;
    tick_to(45);
    check_eq("en_restart_cols", {28'd0, cols}, 32'hE);
    check_eq("en_pressed_strobes", strobe_cnt - s0, 1);

    // 6b: enable low while DEBOUNCE
    do_reset();
    s0 = strobe_cnt;
    pressed = 16'h0040;
    tick_to(13);
    check_eq("en_deb_frozen", {28'd0, cols}, 32'hD);
    enable  = 1'b0;
    pressed = 16'h0000;
    tick_to(14);
    check_eq("en_deb_cols", {28'd0, cols}, 32'hF);
    check_eq("en_deb_held", {31'd0, key_held}, 32'h0);
    tick_to(15);
    enable = 1'b1;
    tick_to(16);
    check_eq("en_deb_restart", {28'd0, cols}, 32'hE);
    tick_to(30);
    check_eq("en_deb_no_strobe", strobe_cnt - s0, 0);

    // 6c: reset while DEBOUNCE
    do_reset();
    s0 = strobe_cnt;
    pressed = 16'h0040;
    tick_to(13);
    check_eq("rst_deb_frozen", {28'd0, cols}, 32'hD);
    pressed = 16'h0000;
    do_reset();
    check_eq("rst_deb_cols", {28'd0, cols}, 32'hE);
    check_eq("rst_deb_held", {31'd0, key_held}, 32'h0);
    tick_to(20);
    check_eq("rst_deb_no_strobe", strobe_cnt - s0, 0);

    // 6d: reset while PRESSED
    do_reset();
    s0 = strobe_cnt;
    pressed = 16'h0040;
    tick_to(20);
    check_eq("rst_prs_held", {31'd0, key_held}, 32'h1);
    check_eq("rst_prs_keypos", {28'd0, key_pos}, 32'h6);
    pressed = 16'h0000;
    do_reset();
    check_eq("rst_prs_keypos0", {28'd0, key_pos}, 32'h0);
    check_eq("rst_prs_held0", {31'd0, key_held}, 32'h0);
    check_eq("rst_prs_cols", {28'd0, cols}, 32'hE);
    tick_to(20);
    check_eq("rst_prs_strobes", strobe_cnt - s0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
